barrett_reduce_pipe: RTL and testbench
======================================

Name: barrett_reduce_pipe

Overview:
Pipelined Barrett modular reducer: y = x mod q for a 2K-bit operand, with one result per cycle at full throughput.
Successor to the combinational reducer used in the HE datapath. Adds a generalised width K, a runtime-loadable modulus (q, mu), a valid/ready stream handshake and backpressure.
Sits between the NTT/polynomial multipliers and the coefficient memories.

Parameters:
K, 32, modulus bit width; q must satisfy 2^(K-1) < q < 2^K
Q_INIT, 32'hFFFF_FFFB, modulus value loaded at reset
MU_INIT, floor(2^(2K)/Q_INIT), Barrett constant loaded at reset (K+1 bits)
RUNTIME_Q, 1, 1 = q_load port active; 0 = q_load ignored and modulus fixed at Q_INIT/MU_INIT

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
x  in  2K  operand to reduce
in_valid  in  1  x valid
in_ready  out  1  block accepts x this cycle
y  out  K  result, 0 <= y < q
out_valid  out  1  y valid
out_ready  in  1  consumer accepts y
q_load  in  1  load new modulus (single-cycle pulse)
q_in  in  K  new q
mu_in  in  K+1  new mu = floor(2^(2K)/q_in), precomputed by software
q_busy  out  1  pipeline holds data; q_load is ignored while high

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all stage valid bits = 0, out_valid = 0, y = 0, q_busy = 0
  - q_reg = Q_INIT, mu_reg = MU_INIT
- Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv && !q_load_take.
  - When adv = 0, every stage register holds its value (no bubbles collapse).
- Pipeline, 4 register stages; latency 4 cycles from accept to out_valid with out_ready held high:
  - S1: register x; q1 = x >> (K-1) (K+1 bits).
  - S2: q2 = q1 * mu_reg (2K+2 bits); register q3 = q2 >> (K+1) (K+1 bits); carry x.
  - S3: r = (x - q3*q_reg) mod 2^(K+2); register r. Guaranteed 0 <= r < 3q.
  - S4: r' = (r >= q) ? r - q : r; y = (r' >= q) ? r' - q : r'; register y and out_valid.
- Throughput: one result per cycle when out_ready is held high. In-order; no drops; no duplicates.
- Output y stays stable while out_valid=1 and out_ready=0.
- q_busy = OR of all stage valids.
- Modulus load:
  - q_load_take = q_load && !q_busy && RUNTIME_Q.
  - On take: q_reg <= q_in, mu_reg <= mu_in, and in_valid is not accepted that cycle (in_ready = 0).
  - q_load while q_busy = 1 is ignored with no side effect; the caller retries.
- Reset mid-operation: all in-flight data is discarded and the modulus reverts to Q_INIT/MU_INIT.
- No check is made on q_in range or mu_in consistency; software guarantees them.
- Multiplier stages may be retimed internally, but the latency must stay exactly 4.

Decomposition:
- Package barrett_pkg: K default, Q_INIT/MU_INIT constants (generated alongside precompute.vh), and a function mu_of(q) for benches only.
- Natural sub-module: barrett_cond_sub (S4 double conditional subtract, parameter K), reused by the modular adder.

Test Plan:
1. K=14, reload q=12289 / mu=21843 when idle; x=150994944 ((q-1)^2) -> y=1 exactly 4 cycles after accept.
2. Same q; back-to-back stream x = 0, 12289, 12290, 268435455 with out_ready=1 -> y = 0, 0, 1, 6828 on consecutive cycles.
3. Backpressure: out_ready=0 for 5 cycles mid-stream -> in_ready falls and y holds stable; after release, all results arrive in order with none lost or duplicated.
4. q_load pulse while q_busy=1 -> ignored; q_reg unchanged (next result still reduces by 12289). Retry after drain -> accepted, and in_ready=0 that cycle.
5. Random 10k operands x < 2^28, random out_ready -> every y matches x % q, and every y < q.
6. rst_n asserted with 3 items in flight -> out_valid=0 and y=0 immediately (async), and the modulus returns to Q_INIT.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared constants for the Barrett reducer: default width, reset-time modulus and a
// reference helper for computing mu.
package barrett_pkg;

    localparam int unsigned K_DEFAULT = 32;
    localparam logic [31:0] Q_INIT_DEFAULT = 32'hFFFF_FFFB;
    // floor(2^64 / (2^32 - 5)) = 2^32 + 5
    localparam logic [32:0] MU_INIT_DEFAULT = 33'h1_0000_0005;

    // Reference mu = floor(2^(2k) / q); not intended for synthesis.
    function automatic logic [63:0] mu_of(input logic [63:0] q, input int unsigned k);
        logic [127:0] num;
        num = 128'd1 << (2 * k);
        return 64'(num / {64'd0, q});
    endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Double conditional subtract: folds r in [0, 3q) into [0, q).
module barrett_cond_sub
    import barrett_pkg::*;
#(
    parameter int unsigned K = K_DEFAULT
) (
    input  logic [K+1:0] r,
    input  logic [K-1:0] q,
    output logic [K-1:0] y
);

    logic [K+1:0] q_ext;
    logic [K+1:0] r1;
    logic [K+1:0] r2;

    always_comb begin
        q_ext = {2'b00, q};
        r1    = (r >= q_ext) ? r - q_ext : r;
        r2    = (r1 >= q_ext) ? r1 - q_ext : r1;
        y     = K'(r2);
    end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Four-stage pipelined Barrett reducer y = x mod q with valid/ready handshake, global stall
// and a modulus that can be reloaded while the pipeline is empty.
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int unsigned  K         = K_DEFAULT,
    parameter logic [K-1:0] Q_INIT    = K'(Q_INIT_DEFAULT),
    parameter logic [K:0]   MU_INIT   = (K+1)'(MU_INIT_DEFAULT),
    parameter bit           RUNTIME_Q = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2*K-1:0] x,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [K-1:0]   y,
    output logic           out_valid,
    input  logic           out_ready,
    input  logic           q_load,
    input  logic [K-1:0]   q_in,
    input  logic [K:0]     mu_in,
    output logic           q_busy
);

    logic adv;
    logic q_load_take;

    logic [K-1:0]   q_q;
    logic [K:0]     mu_q;

    logic           v1_q, v2_q, v3_q, v4_q;
    logic [2*K-1:0] x1_q, x2_q;
    logic [K:0]     q3_q;
    logic [K+1:0]   r3_q;
    logic [K-1:0]   y_q;

    logic [K:0]     q1;
    logic [2*K+1:0] q2;
    logic [K:0]     q3_d;
    logic [2*K:0]   qq;
    logic [K+1:0]   r_d;
    logic [K-1:0]   y_d;

    assign q_busy      = v1_q | v2_q | v3_q | v4_q;
    assign adv         = !v4_q || out_ready;
    assign q_load_take = q_load && !q_busy && RUNTIME_Q;
    assign in_ready    = adv && !q_load_take;

    assign out_valid = v4_q;
    assign y         = y_q;

    // Modulus may only change with nothing in flight, so no stage ever mixes two moduli.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q  <= Q_INIT;
            mu_q <= MU_INIT;
        end else if (q_load_take) begin
            q_q  <= q_in;
            mu_q <= mu_in;
        end
    end

    always_comb begin
        q1   = (K+1)'(x1_q >> (K - 1));
        q2   = (2*K+2)'(q1) * (2*K+2)'(mu_q);
        q3_d = (K+1)'(q2 >> (K + 1));
        qq   = (2*K+1)'(q3_q) * (2*K+1)'(q_q);
        // Only the low K+2 bits matter: the true remainder is below 3q < 2^(K+2).
        r_d  = (K+2)'({1'b0, x2_q} - qq);
    end

    barrett_cond_sub #(
        .K (K)
    ) u_cond_sub (
        .r (r3_q),
        .q (q_q),
        .y (y_d)
    );

    // Single enable for every stage: a stall freezes the whole pipe, bubbles included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            x1_q <= '0;
            x2_q <= '0;
            q3_q <= '0;
            r3_q <= '0;
            y_q  <= '0;
        end else if (adv) begin
            v1_q <= in_valid && in_ready;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            if (in_valid && in_ready) begin
                x1_q <= x;
            end
            if (v1_q) begin
                x2_q <= x1_q;
                q3_q <= q3_d;
            end
            if (v2_q) begin
                r3_q <= r_d;
            end
            if (v3_q) begin
                y_q <= y_d;
            end
        end
    end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Bench for barrett_reduce_pipe at K=14: directed latency, stream, backpressure, modulus-load
// and reset cases plus a long random run, all checked against a plain x % q scoreboard.
module tb_barrett_reduce_pipe;
    import barrett_pkg::*;

    localparam int unsigned K   = 14;
    localparam logic [K-1:0] QI  = 14'd16381;
    localparam logic [K:0]   MUI = 15'd16387;

    logic           clk;
    logic           rst_n;
    logic [2*K-1:0] x;
    logic           in_valid;
    logic           in_ready;
    logic [K-1:0]   y;
    logic           out_valid;
    logic           out_ready;
    logic           q_load;
    logic [K-1:0]   q_in;
    logic [K:0]     mu_in;
    logic           q_busy;

    barrett_reduce_pipe #(
        .K         (K),
        .Q_INIT    (QI),
        .MU_INIT   (MUI),
        .RUNTIME_Q (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_load    (q_load),
        .q_in      (q_in),
        .mu_in     (mu_in),
        .q_busy    (q_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] exp;
        logic [63:0] q;
    } item_t;

    item_t       sb[$];
    item_t       mon_it;
    logic [63:0] m_q;
    int unsigned checks;
    int unsigned failures;
    int unsigned n_in;
    int unsigned n_out;
    logic        prev_stall;
    logic [K-1:0] prev_y;
    logic        mon_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && (sb.size() != 0 || q_busy); i++) tick();
        check(tag, 64'(sb.size()), 64'd0);
        check({tag, "_busy"}, 64'(q_busy), 64'd0);
    endtask

    task automatic wait_out(input string tag);
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check(tag, 64'(out_valid), 64'd1);
    endtask

    // Reference model: every handshake on the input queues x % q, every output handshake pops.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            mon_busy = sb.size() != 0;
            check("q_busy", 64'(q_busy), 64'(mon_busy));
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_y", 64'(y), 64'(prev_y));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    mon_it = sb.pop_front();
                    check("y", 64'(y), mon_it.exp);
                    check("y_lt_q", 64'(64'(y) < mon_it.q), 64'd1);
                    n_out++;
                end
            end
            if (q_load && !mon_busy) begin
                check("load_in_ready", 64'(in_ready), 64'd0);
                m_q = 64'(q_in);
            end else if (in_valid && in_ready) begin
                sb.push_back('{64'(x) % m_q, m_q});
                n_in++;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    logic [2*K-1:0] t2_x [4];
    logic [K-1:0]   t2_y [4];
    int unsigned    lat;
    int unsigned    sent;
    logic           acc;

    initial begin
        checks   = 0;
        failures = 0;
        n_in     = 0;
        n_out    = 0;
        prev_stall = 1'b0;
        m_q      = 64'(QI);
        rst_n    = 1'b0;
        x        = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        q_load   = 1'b0;
        q_in     = '0;
        mu_in    = '0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_q_busy", 64'(q_busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: reload q=12289 while idle, then (q-1)^2 -> 1 after 4 cycles
        q_load = 1'b1;
        q_in   = 14'd12289;
        mu_in  = 15'd21843;
        tick();
        q_load   = 1'b0;
        in_valid = 1'b1;
        x        = 28'd150994944;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("t1_latency", 64'(lat), 64'd4);
        check("t1_y", 64'(y), 64'd1);
        wait_drain("t1_drain");

        // 2: back-to-back stream, results on consecutive cycles
        t2_x[0] = 28'd0;     t2_y[0] = 14'd0;
        t2_x[1] = 28'd12289; t2_y[1] = 14'd0;
        t2_x[2] = 28'd12290; t2_y[2] = 14'd1;
        t2_x[3] = 28'd268435455; t2_y[3] = 14'd6828;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x        = t2_x[i];
            #1;
            check("t2_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        wait_out("t2_first");
        for (int i = 0; i < 4; i++) begin
            check("t2_consec", 64'(out_valid), 64'd1);
            check("t2_y", 64'(y), 64'(t2_y[i]));
            tick();
        end
        wait_drain("t2_drain");

        // 3: 5-cycle backpressure in the middle of a 12-item stream
        sent     = 0;
        in_valid = 1'b1;
        x        = 28'($urandom);
        for (int c = 0; c < 40 && sent < 12; c++) begin
            out_ready = (c < 6 || c >= 11);
            #2;
            acc = in_valid && in_ready;
            if (c == 10) check("t3_in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                x = 28'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t3_sent", 64'(sent), 64'd12);
        wait_drain("t3_drain");
        check("t3_count", 64'(n_out), 64'(n_in));

        // 4: q_load while busy is ignored; retry after drain is taken with in_ready low
        in_valid = 1'b1;
        x        = 28'd150994944;
        tick();
        in_valid = 1'b0;
        q_load   = 1'b1;
        q_in     = 14'd10007;
        mu_in    = 15'(mu_of(64'd10007, K));
        #1;
        check("t4_busy", 64'(q_busy), 64'd1);
        check("t4_ignored_in_ready", 64'(in_ready), 64'd1);
        tick();
        q_load   = 1'b0;
        in_valid = 1'b1;
        x        = 28'd268435455;
        tick();
        in_valid = 1'b0;
        wait_drain("t4_drain1");
        q_load   = 1'b1;
        in_valid = 1'b1;
        x        = 28'd5;
        #1;
        check("t4_take_in_ready", 64'(in_ready), 64'd0);
        tick();
        q_load = 1'b0;
        x      = 28'd150994944;
        tick();
        in_valid = 1'b0;
        wait_out("t4_out");
        check("t4_new_q", 64'(y), 64'd150994944 % 64'd10007);
        wait_drain("t4_drain2");
        q_load = 1'b1;
        q_in   = 14'd12289;
        mu_in  = 15'd21843;
        tick();
        q_load = 1'b0;

        // 5: random operands with random backpressure
        sent = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            x         = 28'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t5_sent", 64'(sent), 64'd10000);
        wait_drain("t5_drain");

        // 6: asynchronous reset with three items in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 28'd12290 + 28'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("t6_stalled_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        m_q = 64'(QI);
        #1;
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_y", 64'(y), 64'd0);
        check("t6_q_busy", 64'(q_busy), 64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1;
        x        = 28'd150994944;
        tick();
        in_valid = 1'b0;
        wait_out("t6_out");
        check("t6_q_init", 64'(y), 64'd150994944 % 64'(QI));
        wait_drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
